// File: rtl/addr_gen_nd.sv
// addr_gen_nd: N-dimensional strided address generator with optional ring wrap
module addr_gen_nd #(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16,
  parameter int NDIM   = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ADDR_W-1:0]      cfg_base,
  input  logic [NDIM*CNT_W-1:0]  cfg_count,
  input  logic [NDIM*ADDR_W-1:0] cfg_stride,
  input  logic                   cfg_wrap_en,
  input  logic [ADDR_W-1:0]      cfg_wrap_lo,
  input  logic [ADDR_W-1:0]      cfg_wrap_size,
  input  logic                   start,
  input  logic                   abort,
  output logic                   busy,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ADDR_W-1:0]      out_addr,
  output logic [NDIM*CNT_W-1:0]  out_idx,
  output logic [NDIM-1:0]        out_last,
  output logic                   done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [NDIM*CNT_W-1:0] cnt_q, idx_q, idx_n;
  logic [NDIM*ADDR_W-1:0] stride_q, anchor_q, anchor_n;
  logic [ADDR_W-1:0] lo_q, size_q, addr_q, sum, nxt;
  logic wrap_en_q, valid_q, done_q, any_zero, run_last;
  logic [NDIM:0] al;

  // al[d]: every dim below d sits on its final iteration (al[d+1] is out_last[d])
  always_comb begin
    al = '0;
    run_last = 1'b1;
    any_zero = 1'b0;
    al[0] = 1'b1;
    for (int d = 0; d < NDIM; d++) begin
      run_last = run_last & (idx_q[d*CNT_W +: CNT_W] == cnt_q[d*CNT_W +: CNT_W] - CNT_W'(1));
      al[d+1] = run_last;
      any_zero = any_zero | (cfg_count[d*CNT_W +: CNT_W] == '0);
    end
  end

  // Next point: the carry dim k steps its anchor, every dim at or below k restarts from it
  always_comb begin
    sum = '0;
    idx_n = idx_q;
    anchor_n = anchor_q;
    for (int d = 0; d < NDIM; d++)
      if (al[d] & ~al[d+1]) sum = anchor_q[d*ADDR_W +: ADDR_W] + stride_q[d*ADDR_W +: ADDR_W];
    nxt = (wrap_en_q && (sum - lo_q) >= size_q) ? sum - size_q : sum;
    for (int d = 0; d < NDIM; d++)
      if (al[d]) begin
        idx_n[d*CNT_W +: CNT_W] = al[d+1] ? '0 : idx_q[d*CNT_W +: CNT_W] + CNT_W'(1);
        anchor_n[d*ADDR_W +: ADDR_W] = nxt;
      end
  end

  // Walk FSM with registered stream outputs; abort overrides everything once a walk is live
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      valid_q <= 1'b0;
      done_q <= 1'b0;
      cnt_q <= '0;
      stride_q <= '0;
      wrap_en_q <= 1'b0;
      lo_q <= '0;
      size_q <= '0;
      anchor_q <= '0;
      idx_q <= '0;
      addr_q <= '0;
    end else if (state == IDLE) begin
      if (start && !abort) begin
        cnt_q <= cfg_count;
        stride_q <= cfg_stride;
        wrap_en_q <= cfg_wrap_en;
        lo_q <= cfg_wrap_lo;
        size_q <= cfg_wrap_size;
        anchor_q <= {NDIM{cfg_base}};
        idx_q <= '0;
        addr_q <= cfg_base;
        state <= any_zero ? DONE : RUN;
        valid_q <= !any_zero;
        done_q <= any_zero;
      end
    end else if (abort) begin
      state <= IDLE;
      valid_q <= 1'b0;
      done_q <= 1'b0;
    end else if (state == DONE) begin
      state <= IDLE;
      done_q <= 1'b0;
    end else if (out_ready) begin
      if (al[NDIM]) begin
        state <= DONE;
        valid_q <= 1'b0;
        done_q <= 1'b1;
      end else begin
        idx_q <= idx_n;
        anchor_q <= anchor_n;
        addr_q <= nxt;
      end
    end
  end

  assign busy = state != IDLE;
  assign out_valid = valid_q;
  assign out_addr = addr_q;
  assign out_idx = idx_q;
  assign out_last = al[NDIM:1];
  assign done = done_q;
endmodule

// File: tb/tb_addr_gen_nd.sv
// tb_addr_gen_nd: randomized walks checked against a closed-form loop-nest model
module tb_addr_gen_nd;
  logic clk, rst_n;
  logic [15:0] cfg_base, cfg_wrap_lo, cfg_wrap_size;
  logic [47:0] cfg_count, cfg_stride;
  logic cfg_wrap_en, start, abort, out_ready;
  logic busy, out_valid, done;
  logic [15:0] out_addr;
  logic [47:0] out_idx;
  logic [2:0] out_last;

  typedef struct packed {
    logic [15:0] a;
    logic [47:0] idx;
    logic [2:0] last;
  } beat_t;

  beat_t q[$];
  int vectors = 0, miscompares = 0;
  bit chk_done = 1;

  addr_gen_nd dut (
    .clk(clk), .rst_n(rst_n), .cfg_base(cfg_base), .cfg_count(cfg_count),
    .cfg_stride(cfg_stride), .cfg_wrap_en(cfg_wrap_en), .cfg_wrap_lo(cfg_wrap_lo),
    .cfg_wrap_size(cfg_wrap_size), .start(start), .abort(abort), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_idx(out_idx), .out_last(out_last), .done(done)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", n, act, exp, $time);
    end
  endtask

  // Expected beats: address is base plus sum of idx*stride, folded into the ring when enabled
  task automatic setup(input int b, c0, c1, c2, s0, s1, s2, input bit wen, input int lo, sz);
    beat_t bt;
    longint off;
    int i0, i1, i2;
    cfg_base = 16'(b);
    cfg_count = {16'(c2), 16'(c1), 16'(c0)};
    cfg_stride = {16'(s2), 16'(s1), 16'(s0)};
    cfg_wrap_en = wen;
    cfg_wrap_lo = 16'(lo);
    cfg_wrap_size = 16'(sz);
    q.delete();
    for (int n = 0; n < c0 * c1 * c2; n++) begin
      i0 = n % c0;
      i1 = (n / c0) % c1;
      i2 = n / (c0 * c1);
      off = longint'(i0) * s0 + longint'(i1) * s1 + longint'(i2) * s2;
      bt.a = wen ? 16'(lo + ((b - lo) + off) % sz) : 16'(b + off);
      bt.idx = {16'(i2), 16'(i1), 16'(i0)};
      bt.last[0] = (i0 == c0 - 1);
      bt.last[1] = bt.last[0] && (i1 == c1 - 1);
      bt.last[2] = bt.last[1] && (i2 == c2 - 1);
      q.push_back(bt);
    end
  endtask

  task automatic run(input bit rnd, input bit poke);
    bit seen = 0;
    out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    start = 1;
    for (int it = 0; it < 600 && !seen; it++) begin
      @(posedge clk); #1;
      start = poke && it == 5;
      if (start) cfg_base = 16'hdead;
      if (done) seen = 1;
      else out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    start = 0;
    if (!seen) chk("done_timeout", done, 1);
    chk("beats_left", q.size(), 0);
    @(posedge clk); #1;
  endtask

  // Every cycle: beats against the model, done exactly after the final handshake, stalls hold
  initial begin
    bit pend = 0, pstall = 0, pabort = 0;
    logic [15:0] pa;
    logic [47:0] pi;
    logic [2:0] pl;
    beat_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend = 0;
        pstall = 0;
        continue;
      end
      if (chk_done) chk("done", done, pend);
      pend = 0;
      if (pstall && !pabort) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_addr", out_addr, pa);
        chk("stall_idx", out_idx, pi);
        chk("stall_last", out_last, pl);
      end
      if (out_valid) begin
        chk("busy", busy, 1);
        if (q.size() == 0) chk("extra_beat", out_valid, 0);
        else begin
          e = q[0];
          chk("addr", out_addr, e.a);
          chk("idx", out_idx, e.idx);
          chk("last", out_last, e.last);
          if (out_ready) begin
            void'(q.pop_front());
            pend = e.last[2];
          end
        end
      end
      pstall = out_valid & !out_ready;
      pabort = abort;
      pa = out_addr;
      pi = out_idx;
      pl = out_last;
    end
  end

  initial begin
    int exp2 [8] = '{0, 1, 10, 11, 100, 101, 110, 111};
    int exp4 [8] = '{'h20c, 'h20e, 'h200, 'h202, 'h204, 'h206, 'h208, 'h20a};
    int c0, c1, c2, s0, s1, s2, b, lo, sz, nd, first;
    bit wen;
    rst_n = 0; start = 0; abort = 0; out_ready = 0;
    cfg_base = 0; cfg_count = 0; cfg_stride = 0; cfg_wrap_en = 0; cfg_wrap_lo = 0; cfg_wrap_size = 0;
    #2;
    chk("rst_valid", out_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_addr", out_addr, 0);
    chk("rst_idx", out_idx, 0);
    chk("rst_last", out_last, 0);
    @(posedge clk); #1; rst_n = 1;
    @(posedge clk); #1;
    // 2D walk, full throughput
    setup('h100, 4, 3, 1, 1, 'h40, 0, 0, 0, 0);
    chk("m1_size", q.size(), 12);
    chk("m1_b5", q[4].a, 'h140);
    chk("m1_b12", q[11].a, 'h183);
    chk("m1_last4", q[3].last, 3'b001);
    chk("m1_last12", q[11].last, 3'b111);
    run(0, 0);
    // 3D walk
    setup(0, 2, 2, 2, 1, 10, 100, 0, 0, 0);
    for (int i = 0; i < 8; i++) chk("m2_addr", q[i].a, exp2[i]);
    run(0, 0);
    // 2D walk under random backpressure
    setup('h100, 4, 3, 1, 1, 'h40, 0, 0, 0, 0);
    run(1, 0);
    // Ring wrap
    setup('h20c, 8, 1, 1, 2, 0, 0, 1, 'h200, 'h10);
    for (int i = 0; i < 8; i++) chk("m4_addr", q[i].a, exp4[i]);
    run(1, 0);
    // Zero count: no beats, a single done pulse
    setup('h100, 4, 0, 1, 1, 'h40, 0, 0, 0, 0);
    chk_done = 0;
    nd = 0;
    first = 0;
    start = 1;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      start = 0;
      chk("degen_valid", out_valid, 0);
      if (done) begin
        nd++;
        if (first == 0) first = i;
      end
    end
    chk("degen_pulses", nd, 1);
    chk("degen_when", first >= 1 && first <= 2, 1);
    chk_done = 1;
    // Start while running is ignored
    setup('h100, 4, 3, 1, 1, 'h40, 0, 0, 0, 0);
    run(0, 1);
    // Abort after three beats
    setup('h100, 4, 3, 1, 1, 'h40, 0, 0, 0, 0);
    out_ready = 1;
    start = 1;
    @(posedge clk); #1; start = 0;
    repeat (3) @(posedge clk);
    #1; abort = 1; out_ready = 0;
    @(negedge clk); #1; q.delete();
    @(posedge clk); #1; abort = 0;
    chk("abort_valid", out_valid, 0);
    chk("abort_done", done, 0);
    chk("abort_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    setup('h100, 4, 3, 1, 1, 'h40, 0, 0, 0, 0);
    run(0, 0);
    // Random configurations
    for (int t = 0; t < 25; t++) begin
      c0 = $urandom_range(1, 4); c1 = $urandom_range(1, 4); c2 = $urandom_range(1, 4);
      wen = 1'($urandom_range(0, 1));
      if (wen) begin
        sz = $urandom_range(2, 64);
        lo = $urandom_range(0, 'h7fff);
        b = lo + $urandom_range(0, sz - 1);
        s0 = $urandom_range(0, sz - 1); s1 = $urandom_range(0, sz - 1); s2 = $urandom_range(0, sz - 1);
      end else begin
        sz = 0; lo = 0;
        b = $urandom_range(0, 'hffff);
        s0 = $urandom_range(0, 'hffff); s1 = $urandom_range(0, 'hffff); s2 = $urandom_range(0, 'hffff);
      end
      setup(b, c0, c1, c2, s0, s1, s2, wen, lo, sz);
      run(1, 0);
    end
    // Reset in the middle of a walk
    setup('h100, 4, 3, 1, 1, 'h40, 0, 0, 0, 0);
    out_ready = 1;
    start = 1;
    @(posedge clk); #1; start = 0;
    repeat (2) @(posedge clk);
    #1; rst_n = 0;
    #1;
    chk("mrst_valid", out_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_addr", out_addr, 0);
    q.delete();
    @(posedge clk); #1; rst_n = 1;
    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
